alu_req_arbiter: RTL
====================

Name: alu_req_arbiter

Overview:
- Shares the single 8-bit add/subtract ALU between two requesters: arbitrates, sequences the ALU controls (operands, sub, sumout, flagsin) and returns the result plus registered carry/zero flags.
- Sits between two client blocks and the ALU instance.
- One operation in flight at a time.
- Round-robin fairness between requesters.

Parameters:
- DATA_W, 8, operand/result width; must be 8 to match the ALU.
- PRIO_INIT, 0, requester that wins the first contended arbitration after reset (0 or 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  00 ADD, 01 SUB, 10 CMP, 11 FLAGS.
- req0_a  in  8  operand a.
- req0_b  in  8  operand b.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that issued the response.
- rsp_result  out  8  ALU sum; 0 for CMP/FLAGS.
- rsp_cf  out  1  carry flag.
- rsp_zf  out  1  zero flag.
- alu_a  out  8  to ALU a.
- alu_b  out  8  to ALU b.
- alu_sub  out  1  to ALU sub.
- alu_sumout  out  1  to ALU sumout.
- alu_flagsin  out  1  to ALU flagsin.
- alu_out  in  8  ALU out.
- alu_cf  in  1  ALU carryflg.
- alu_zf  in  1  ALU zeroflg.

Behaviour:
- Reset (async, immediate):
  - state IDLE; rsp_valid, rsp_id, rsp_result, rsp_cf, rsp_zf all 0.
  - alu_a, alu_b, alu_sub, alu_sumout, alu_flagsin all 0.
  - Round-robin pointer set so PRIO_INIT wins the next contention.
  - An in-flight operation is dropped silently. The ALU flag registers are not reset by this block.
- States: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - Grant one valid requester. If exactly one is valid, it wins. If both are valid, the one not granted last wins.
  - reqN_ready = (state==IDLE) && grant==N; combinational, at most one high.
  - On accept: register op, a, b and id; update pointer to favour the other requester.
  - Next state is EXEC for ADD/SUB/CMP, CAPT for FLAGS.
  - No accept while not in IDLE; ready low in all other states.
- EXEC (1 cycle):
  - alu_a/alu_b = registered operands.
  - alu_sub = 1 for SUB and CMP.
  - alu_flagsin = 1.
  - alu_sumout = 1 for ADD/SUB only.
  - At the closing edge, rsp_result captures alu_out (0 for CMP, since sumout is low); the ALU latches its flags on the same edge.
  - alu_* controls return to 0 in every state except EXEC. Operand outputs also return to 0.
- CAPT (1 cycle):
  - Flags are now valid at alu_cf/alu_zf; capture them into rsp_cf/rsp_zf.
  - For FLAGS, capture the ALU's current (previous-operation) flags, with rsp_result = 0.
  - Next state RESP.
- RESP:
  - rsp_valid = 1; all rsp_* held stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid drops next cycle, state IDLE. A new accept is possible no earlier than the cycle after the response handshake.
- Latency:
  - Accept at edge T, rsp_valid high after edge T+2 (ADD/SUB/CMP). FLAGS is one cycle shorter.
  - Peak throughput: one operation per 4 cycles with rsp_ready tied high.
- Arithmetic:
  - SUB is a + ~b + 1; cf = 1 means a >= b (no borrow).
  - zf = (8-bit result == 0).
  - ADD cf = bit-8 carry-out.
- Requests must hold valid/op/a/b stable until ready. A requester deasserting valid before grant is legal; it simply is not granted.
- Both valid with one repeatedly re-asserting: strict alternation; no starvation.

Test Plan:
- ADD via req0: a=0xFF, b=0x01 -> after 3 cycles rsp_valid, id=0, result=0x00, cf=1, zf=1; alu_sumout/alu_flagsin high for exactly 1 cycle.
- SUB via req1: 0x05-0x03 -> result=0x02, cf=1, zf=0. Then 0x03-0x05 -> result=0xFE, cf=0, zf=0.
- CMP a=0x42, b=0x42 -> result=0x00, zf=1, cf=1, alu_sumout never high. A following FLAGS request returns cf=1, zf=1, result 0, with no EXEC cycle.
- Both valid continuously, 6 ops, PRIO_INIT=0 -> grant order 0,1,0,1,0,1. Never both ready high.
- Backpressure: rsp_ready low for 5 cycles -> rsp_* stable, req ready stays low. Release -> IDLE, next grant on the following cycle.
- rst asserted during EXEC -> outputs zero immediately. After release, a new ADD 0x10+0x20 completes normally with result=0x30, cf=0, zf=0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Two-requester front end for the shared 8-bit add/subtract ALU.
// Picks one requester at a time (round-robin when both ask), drives the ALU
// control strobes for one operation, and returns the sum plus the flags the
// ALU latched for that operation.
module alu_req_arbiter #(
  parameter int DATA_W    = 8,
  parameter int PRIO_INIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_cf,
  output logic              rsp_zf,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_sub,
  output logic              alu_sumout,
  output logic              alu_flagsin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cf,
  input  logic              alu_zf
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_CMP   = 2'b10;
  localparam logic [1:0] OP_FLAGS = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                id_q, id_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                cf_q, cf_d;
  logic                zf_q, zf_d;

  logic                grant;
  logic                grantValid;
  logic [1:0]          selOp;
  logic [DATA_W-1:0]   selA;
  logic [DATA_W-1:0]   selB;

  // Choose a winner while idle; on contention prio_q names the favoured requester.
  always_comb begin
    grant      = 1'b0;
    grantValid = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant      = prio_q;
        grantValid = 1'b1;
      end else if (req0_valid) begin
        grant      = 1'b0;
        grantValid = 1'b1;
      end else if (req1_valid) begin
        grant      = 1'b1;
        grantValid = 1'b1;
      end
    end
  end

  assign req0_ready = grantValid && !grant;
  assign req1_ready = grantValid && grant;

  assign selOp = grant ? req1_op : req0_op;
  assign selA  = grant ? req1_a  : req0_a;
  assign selB  = grant ? req1_b  : req0_b;

  // Sequence one operation: accept, drive the ALU for one cycle, collect flags, hand back.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    result_d    = result_q;
    cf_d        = cf_q;
    zf_d        = zf_q;
    alu_a       = '0;
    alu_b       = '0;
    alu_sub     = 1'b0;
    alu_sumout  = 1'b0;
    alu_flagsin = 1'b0;
    rsp_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grantValid) begin
          op_d     = selOp;
          a_d      = selA;
          b_d      = selB;
          id_d     = grant;
          prio_d   = !grant;
          result_d = '0;
          state_d  = (selOp == OP_FLAGS) ? CAPT : EXEC;
        end
      end
      EXEC: begin
        alu_a       = a_q;
        alu_b       = b_q;
        alu_sub     = (op_q == OP_SUB) || (op_q == OP_CMP);
        alu_sumout  = (op_q == OP_ADD) || (op_q == OP_SUB);
        alu_flagsin = 1'b1;
        if (op_q != OP_CMP) begin
          result_d = alu_out;
        end
        state_d = CAPT;
      end
      CAPT: begin
        cf_d    = alu_cf;
        zf_d    = alu_zf;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured request/response registers; reset drops any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= (PRIO_INIT != 0);
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
    end
  end

  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_cf     = cf_q;
  assign rsp_zf     = zf_q;

endmodule
